// File: rtl/qbus_mscp_regs.sv
// Qbus slave register window for N_CTRL MSCP controllers (IR/SA pairs) plus a host-side event/mask/SA view.
// Optional macro QBUS_REPLY_DELAY_EN holds BRPLYg off for REPLY_DELAY clocks inside REPLY.
module qbus_mscp_regs #(
  parameter int          N_CTRL      = 2,
  parameter logic [21:0] QADDR_BASE  = 22'o17772150,
  parameter int          SYNC_STAGES = 2,
  parameter int          REPLY_DELAY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [21:0] BDALf_IN,
  input  logic        BSYNCf,
  input  logic        BDINf,
  input  logic        BDOUTf,
  input  logic        BWTBTf,
  input  logic        BBS7f,
  input  logic        BINITf,
  output logic [21:0] BDALf_OUT,
  output logic [21:0] BDALf_OE,
  output logic        Outbound,
  output logic        BRPLYg,
  input  logic [2:0]  h_addr,
  input  logic        h_rd,
  input  logic        h_wr,
  input  logic [15:0] h_wdata,
  input  logic [1:0]  h_be,
  output logic [15:0] h_rdata,
  output logic        h_rvalid,
  output logic        irq
);

  if (N_CTRL < 1 || N_CTRL > 4 || SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
      REPLY_DELAY < 0 || REPLY_DELAY > 255) begin : g_bad_param
    $error("qbus_mscp_regs: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SEL, S_MISS, S_READ, S_WRITE, S_REPLY} state_t;

  localparam logic [2:0] NCH = 3'(N_CTRL);

  state_t      state_q, state_d;
  logic [3:0]  sync_pipe [SYNC_STAGES];
  logic        sync_a, din_a, dout_a, binit_a;
  logic [12:0] offset;
  logic        addr_hit;
  logic [1:0]  ch_q;
  logic        reg_q, byte_q, rd_q;
  logic        reply_on, drive;
  logic [3:0]  ev_q   [4];
  logic [3:0]  mask_q [4];
  logic [15:0] sa_status  [4];
  logic [15:0] sa_address [4];
  logic [3:0]  ev_set [4];
  logic        ev_clr [4];
  logic [1:0]  h_ch;
  logic        h_ok, irq_d;
  logic        unused_bdal;

  // Strobes are packed {BINIT, DOUT, DIN, SYNC}; negated (high) out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= 4'hF;
    end else begin
      sync_pipe[0] <= {BINITf, BDOUTf, BDINf, BSYNCf};
      for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign sync_a  = ~sync_pipe[SYNC_STAGES-1][0];
  assign din_a   = ~sync_pipe[SYNC_STAGES-1][1];
  assign dout_a  = ~sync_pipe[SYNC_STAGES-1][2];
  assign binit_a = ~sync_pipe[SYNC_STAGES-1][3];

  // Addresses below the base wrap to large offsets and therefore miss.
  assign offset      = ~BDALf_IN[12:0] - QADDR_BASE[12:0];
  assign addr_hit    = ~BBS7f && (offset < 13'(4 * N_CTRL));
  assign unused_bdal = ^BDALf_IN[21:16];

  always_comb begin
    state_d = state_q;
    if (binit_a) begin
      state_d = S_IDLE;
    end else if (state_q != S_IDLE && !sync_a) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (sync_a) state_d = S_ADDR;
        S_ADDR:  state_d = addr_hit ? S_SEL : S_MISS;
        S_SEL:   if (din_a) state_d = S_READ; else if (dout_a) state_d = S_WRITE;
        S_READ:  state_d = S_REPLY;
        S_WRITE: state_d = S_REPLY;
        S_REPLY: if (reply_on && !din_a && !dout_a) state_d = S_SEL;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      reg_q   <= 1'b0;
      byte_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ADDR) {ch_q, reg_q, byte_q} <= offset[3:0];
      if (state_q == S_SEL)  rd_q <= din_a;
    end
  end

`ifdef QBUS_REPLY_DELAY_EN
  localparam logic [7:0] RD = 8'(REPLY_DELAY);
  logic [7:0] dly_q;

  always_ff @(posedge clock) begin
    if (reset)                   dly_q <= RD;
    else if (state_q != S_REPLY) dly_q <= RD;
    else if (dly_q != 8'd0)      dly_q <= dly_q - 8'd1;
  end

  assign reply_on = (dly_q == 8'd0);
`else
  assign reply_on = 1'b1;
`endif

  assign drive     = (state_q == S_READ) || (state_q == S_REPLY && rd_q);
  assign BDALf_OE  = drive ? 22'h3FFFFF : 22'h0;
  assign Outbound  = drive;
  assign BDALf_OUT = (drive && reg_q) ? {6'b0, sa_status[ch_q]} : 22'h0;
  assign BRPLYg    = (state_q == S_REPLY) && reply_on;

  assign h_ch = h_addr[2:1];
  assign h_ok = {1'b0, h_ch} < NCH;

  // Event bits per channel: [0] ir_read, [1] ir_written, [2] sa_read, [3] sa_written.
  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ev_set[i] = 4'b0;
      ev_clr[i] = h_rd && !h_addr[0] && (h_ch == 2'(i));
      if (ch_q == 2'(i)) begin
        if (state_q == S_READ)       ev_set[i] = reg_q ? 4'b0100 : 4'b0001;
        else if (state_q == S_WRITE) ev_set[i] = reg_q ? 4'b1000 : 4'b0010;
      end
      irq_d = irq_d | (|(ev_q[i] & mask_q[i]));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        ev_q[i]       <= '0;
        mask_q[i]     <= '0;
        sa_status[i]  <= '0;
        sa_address[i] <= '0;
      end
      h_rdata  <= '0;
      h_rvalid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      h_rvalid <= h_rd;
      h_rdata  <= '0;
      if (h_rd && h_ok)
        h_rdata <= h_addr[0] ? sa_address[h_ch] : {8'b0, mask_q[h_ch], ev_q[h_ch]};
      irq <= irq_d;
      for (int i = 0; i < 4; i++) begin
        if (i < N_CTRL) begin
          // A set arriving with the host clear survives it.
          ev_q[i] <= binit_a ? 4'b0 : ((ev_q[i] & {4{~ev_clr[i]}}) | ev_set[i]);
          if (h_wr && h_ok && h_ch == 2'(i)) begin
            if (!h_addr[0] && h_be[0]) mask_q[i] <= h_wdata[7:4];
            if (h_addr[0] && h_be[0])  sa_status[i][7:0]  <= h_wdata[7:0];
            if (h_addr[0] && h_be[1])  sa_status[i][15:8] <= h_wdata[15:8];
          end
          if (binit_a) begin
            sa_address[i] <= '0;
          end else if (state_q == S_WRITE && reg_q && ch_q == 2'(i)) begin
            if (!BWTBTf || !byte_q) sa_address[i][7:0]  <= ~BDALf_IN[7:0];
            if (!BWTBTf || byte_q)  sa_address[i][15:8] <= ~BDALf_IN[15:8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_qbus_mscp_regs.sv
// Testbench for qbus_mscp_regs: directed vector table, hand sequences for BINIT and
// same-cycle clear/set, then random traffic against an array-based register model.
module tb_qbus_mscp_regs;
  localparam int N  = 2;
  localparam int SS = 2;
  localparam logic [21:0] BASE = 22'o17772150;

  localparam int OP_HWR = 0, OP_HRD = 1, OP_QRD = 2, OP_QWR = 3, OP_IRQ = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [21:0] BDALf_IN;
  logic        BSYNCf, BDINf, BDOUTf, BWTBTf, BBS7f, BINITf;
  logic [21:0] BDALf_OUT, BDALf_OE;
  logic        Outbound, BRPLYg;
  logic [2:0]  h_addr;
  logic        h_rd, h_wr;
  logic [15:0] h_wdata;
  logic [1:0]  h_be;
  logic [15:0] h_rdata;
  logic        h_rvalid, irq;

  int checks = 0;
  int errors = 0;

  qbus_mscp_regs #(.N_CTRL(N), .QADDR_BASE(BASE), .SYNC_STAGES(SS), .REPLY_DELAY(3)) dut (
    .clock(clock), .reset(reset), .BDALf_IN(BDALf_IN), .BSYNCf(BSYNCf), .BDINf(BDINf),
    .BDOUTf(BDOUTf), .BWTBTf(BWTBTf), .BBS7f(BBS7f), .BINITf(BINITf),
    .BDALf_OUT(BDALf_OUT), .BDALf_OE(BDALf_OE), .Outbound(Outbound), .BRPLYg(BRPLYg),
    .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr), .h_wdata(h_wdata), .h_be(h_be),
    .h_rdata(h_rdata), .h_rvalid(h_rvalid), .irq(irq));

  always #5 clock = ~clock;

  typedef struct {
    int          op;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  ctl;   // host: byte enables; qbus: {word, bs7}
    logic [15:0] exp;
    bit          rep;
  } vec_t;

  vec_t vq[$];
  vec_t v;

  // Reference model: plain per-channel flags and registers.
  bit          m_ir_r [4], m_ir_w [4], m_sa_r [4], m_sa_w [4];
  logic [3:0]  m_mask [4];
  logic [15:0] m_stat [4], m_addr [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    @(posedge clock); #1;
    h_addr = a; h_wdata = d; h_be = be; h_wr = 1'b1;
    @(posedge clock); #1;
    h_wr = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, output logic [15:0] d, output logic val);
    @(posedge clock); #1;
    h_addr = a; h_rd = 1'b1;
    @(posedge clock); #1;
    h_rd = 1'b0;
    @(negedge clock);
    d = h_rdata; val = h_rvalid;
  endtask

  task automatic qbus_xfer(input logic [21:0] addr, input bit wr, input bit bs7, input bit word,
                           input logic [15:0] wdata, output logic [15:0] rdata,
                           output bit replied, output bit drove);
    replied = 1'b0; drove = 1'b0; rdata = '0;
    @(posedge clock); #1;
    BDALf_IN = ~addr; BBS7f = ~bs7; BSYNCf = 1'b0;
    repeat (SS + 3) @(posedge clock);
    #1;
    if (wr) begin
      BDALf_IN = {6'h3F, ~wdata}; BWTBTf = ~word; BDOUTf = 1'b0;
    end else begin
      BDALf_IN = '1; BDINf = 1'b0;
    end
    for (int i = 0; i < 20 && !replied; i++) begin
      @(negedge clock);
      if (BDALf_OE != 22'h0) drove = 1'b1;
      if (BRPLYg) begin
        replied = 1'b1; rdata = BDALf_OUT[15:0];
      end
    end
    @(posedge clock); #1;
    BDINf = 1'b1; BDOUTf = 1'b1;
    for (int i = 0; i < 10 && BRPLYg; i++) @(negedge clock);
    chk("reply_release", BRPLYg, 0);
    @(posedge clock); #1;
    BSYNCf = 1'b1; BBS7f = 1'b1; BWTBTf = 1'b1; BDALf_IN = '1;
    repeat (SS + 2) @(posedge clock);
  endtask

  function automatic logic [15:0] m_ev_word(int ch);
    return {8'b0, m_mask[ch], m_sa_w[ch], m_sa_r[ch], m_ir_w[ch], m_ir_r[ch]};
  endfunction

  function automatic bit m_irq();
    bit r = 1'b0;
    for (int c = 0; c < N; c++) r |= |(m_ev_word(c)[7:4] & m_ev_word(c)[3:0]);
    return r;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 4; c++) begin
      m_ir_r[c] = 0; m_ir_w[c] = 0; m_sa_r[c] = 0; m_sa_w[c] = 0;
      m_mask[c] = '0; m_stat[c] = '0; m_addr[c] = '0;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    m_reset();
  endtask

  logic [15:0] d, d1, d2;
  logic        val;
  bit          rep, drv;

  initial begin
    reset = 1'b1; BDALf_IN = '1; BSYNCf = 1; BDINf = 1; BDOUTf = 1; BWTBTf = 1; BBS7f = 1; BINITf = 1;
    h_addr = '0; h_rd = 0; h_wr = 0; h_wdata = '0; h_be = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_brply", BRPLYg, 0);
    chk("rst_oe", BDALf_OE, 0);
    chk("rst_out", BDALf_OUT, 0);
    chk("rst_outbound", Outbound, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rvalid", h_rvalid, 0);
    chk("rst_rdata", h_rdata, 0);
    #1 reset = 1'b0;

    vq.push_back(vec_t'{OP_HWR, 22'd1, 16'h0400, 2'b11, 16'h0000, 1'b0});
    vq.push_back(vec_t'{OP_QRD, 22'o17772152, 16'h0000, 2'b01, 16'h0400, 1'b1});
    vq.push_back(vec_t'{OP_HRD, 22'd0, 16'h0000, 2'b00, 16'h0004, 1'b0});
    vq.push_back(vec_t'{OP_QWR, 22'o17772157, 16'h5A00, 2'b01, 16'h0000, 1'b1});
    vq.push_back(vec_t'{OP_HRD, 22'd3, 16'h0000, 2'b00, 16'h5A00, 1'b0});
    vq.push_back(vec_t'{OP_HRD, 22'd2, 16'h0000, 2'b00, 16'h0008, 1'b0});
    vq.push_back(vec_t'{OP_HWR, 22'd0, 16'h0010, 2'b01, 16'h0000, 1'b0});
    vq.push_back(vec_t'{OP_QRD, 22'o17772150, 16'h0000, 2'b01, 16'h0000, 1'b1});
    vq.push_back(vec_t'{OP_IRQ, 22'd0, 16'h0000, 2'b00, 16'h0001, 1'b0});
    vq.push_back(vec_t'{OP_HRD, 22'd0, 16'h0000, 2'b00, 16'h0011, 1'b0});
    vq.push_back(vec_t'{OP_HRD, 22'd0, 16'h0000, 2'b00, 16'h0010, 1'b0});
    vq.push_back(vec_t'{OP_IRQ, 22'd0, 16'h0000, 2'b00, 16'h0000, 1'b0});
    vq.push_back(vec_t'{OP_HRD, 22'd4, 16'h0000, 2'b00, 16'h0000, 1'b0});
    vq.push_back(vec_t'{OP_HWR, 22'd7, 16'hFFFF, 2'b11, 16'h0000, 1'b0});
    vq.push_back(vec_t'{OP_HRD, 22'd7, 16'h0000, 2'b00, 16'h0000, 1'b0});
    vq.push_back(vec_t'{OP_QWR, 22'o17772156, 16'h00C3, 2'b01, 16'h0000, 1'b1});
    vq.push_back(vec_t'{OP_HRD, 22'd3, 16'h0000, 2'b00, 16'h5AC3, 1'b0});
    vq.push_back(vec_t'{OP_QWR, 22'o17772152, 16'h1234, 2'b11, 16'h0000, 1'b1});
    vq.push_back(vec_t'{OP_HRD, 22'd1, 16'h0000, 2'b00, 16'h1234, 1'b0});
    vq.push_back(vec_t'{OP_HWR, 22'd1, 16'hAB00, 2'b10, 16'h0000, 1'b0});
    vq.push_back(vec_t'{OP_QRD, 22'o17772152, 16'h0000, 2'b01, 16'hAB00, 1'b1});
    vq.push_back(vec_t'{OP_QRD, 22'o17772160, 16'h0000, 2'b01, 16'h0000, 1'b0});
    vq.push_back(vec_t'{OP_QRD, 22'o17772152, 16'h0000, 2'b00, 16'h0000, 1'b0});
    vq.push_back(vec_t'{OP_HRD, 22'd0, 16'h0000, 2'b00, 16'h001C, 1'b0});
    vq.push_back(vec_t'{OP_HRD, 22'd2, 16'h0000, 2'b00, 16'h0008, 1'b0});
    vq.push_back(vec_t'{OP_HWR, 22'd0, 16'h00F0, 2'b00, 16'h0000, 1'b0});
    vq.push_back(vec_t'{OP_HRD, 22'd0, 16'h0000, 2'b00, 16'h0010, 1'b0});
    vq.push_back(vec_t'{OP_QWR, 22'o17772150, 16'h0000, 2'b01, 16'h0000, 1'b1});
    vq.push_back(vec_t'{OP_IRQ, 22'd0, 16'h0000, 2'b00, 16'h0000, 1'b0});
    vq.push_back(vec_t'{OP_HRD, 22'd0, 16'h0000, 2'b00, 16'h0012, 1'b0});

    foreach (vq[i]) begin
      v = vq[i];
      case (v.op)
        OP_HWR: host_write(v.addr[2:0], v.data, v.ctl);
        OP_HRD: begin
          host_read(v.addr[2:0], d, val);
          chk($sformatf("vec%0d_rvalid", i), val, 1);
          chk($sformatf("vec%0d_rdata", i), d, v.exp);
        end
        OP_QRD: begin
          qbus_xfer(v.addr, 1'b0, v.ctl[0], 1'b0, 16'h0, d, rep, drv);
          chk($sformatf("vec%0d_reply", i), rep, v.rep);
          chk($sformatf("vec%0d_drive", i), drv, v.rep);
          if (v.rep) chk($sformatf("vec%0d_bdal", i), d, v.exp);
        end
        OP_QWR: begin
          qbus_xfer(v.addr, 1'b1, v.ctl[0], v.ctl[1], v.data, d, rep, drv);
          chk($sformatf("vec%0d_reply", i), rep, v.rep);
          chk($sformatf("vec%0d_drive", i), drv, 0);
        end
        default: begin
          repeat (2) @(posedge clock);
          @(negedge clock);
          chk($sformatf("vec%0d_irq", i), irq, v.exp[0]);
        end
      endcase
    end

    // BINIT while a read reply is in progress.
    begin
      int cnt;
      bit got;
      got = 1'b0;
      @(posedge clock); #1;
      BDALf_IN = ~22'o17772152; BBS7f = 1'b0; BSYNCf = 1'b0;
      repeat (SS + 3) @(posedge clock);
      #1 BDALf_IN = '1; BDINf = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clock);
        if (BRPLYg) got = 1'b1;
      end
      chk("binit_reply_seen", got, 1);
      chk("binit_reply_data", BDALf_OUT, 22'h00AB00);
      @(posedge clock); #1;
      BINITf = 1'b0;
      cnt = 0;
      for (int i = 1; i <= 10 && cnt == 0; i++) begin
        @(posedge clock); #1;
        if (!BRPLYg) cnt = i;
      end
      chk("binit_brply_off", (cnt >= 1 && cnt <= SS + 1), 1);
      chk("binit_oe_off", BDALf_OE, 0);
      BINITf = 1'b1; BDINf = 1'b1; BSYNCf = 1'b1; BBS7f = 1'b1;
      repeat (SS + 3) @(posedge clock);
      host_read(3'd0, d, val);
      chk("binit_ev_cleared_mask_kept", d, 16'h0010);
      host_read(3'd1, d, val);
      chk("binit_sa_addr0_cleared", d, 16'h0000);
      host_read(3'd3, d, val);
      chk("binit_sa_addr1_cleared", d, 16'h0000);
      qbus_xfer(22'o17772152, 1'b0, 1'b1, 1'b0, 16'h0, d, rep, drv);
      chk("binit_sa_status_kept", d, 16'hAB00);
    end

    // Host event read sweeping across the cycle in which an IR write event is set.
    for (int k = 4; k <= 12; k++) begin
      host_read(3'd0, d, val);
      fork
        qbus_xfer(22'o17772150, 1'b1, 1'b1, 1'b1, 16'h0, d, rep, drv);
        begin
          repeat (k) @(posedge clock);
          host_read(3'd0, d1, val);
        end
      join
      host_read(3'd0, d2, val);
      chk($sformatf("clr_vs_set_k%0d", k), 32'(d1[1]) + 32'(d2[1]), 1);
    end

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int op, ch, off;
      logic [2:0]  ha;
      logic [15:0] wd;
      logic [1:0]  be;
      bit bs7, word, hit;
      op = $urandom_range(0, 3);
      wd = 16'($urandom);
      case (op)
        0: begin
          ha = 3'($urandom_range(0, 7)); be = 2'($urandom_range(0, 3)); ch = int'(ha[2:1]);
          host_write(ha, wd, be);
          if (ch < N) begin
            if (!ha[0] && be[0]) m_mask[ch] = wd[7:4];
            if (ha[0] && be[0]) m_stat[ch][7:0] = wd[7:0];
            if (ha[0] && be[1]) m_stat[ch][15:8] = wd[15:8];
          end
        end
        1: begin
          logic [15:0] e;
          ha = 3'($urandom_range(0, 7)); ch = int'(ha[2:1]);
          e = 16'h0;
          if (ch < N) begin
            if (ha[0]) e = m_addr[ch];
            else begin
              e = m_ev_word(ch);
              m_ir_r[ch] = 0; m_ir_w[ch] = 0; m_sa_r[ch] = 0; m_sa_w[ch] = 0;
            end
          end
          host_read(ha, d, val);
          chk($sformatf("rnd%0d_hrd_a%0d", n, ha), d, e);
        end
        default: begin
          off  = $urandom_range(0, 4 * N + 3);
          bs7  = ($urandom_range(0, 7) != 0);
          word = 1'($urandom_range(0, 1));
          hit  = bs7 && (off < 4 * N);
          ch   = off / 4;
          qbus_xfer(BASE + 22'(off), op == 3, bs7, word, wd, d, rep, drv);
          chk($sformatf("rnd%0d_reply_off%0d", n, off), rep, hit);
          if (op == 2) begin
            chk($sformatf("rnd%0d_drive", n), drv, hit);
            if (hit) begin
              if ((off % 4) >= 2) begin
                chk($sformatf("rnd%0d_sa_data", n), d, m_stat[ch]);
                m_sa_r[ch] = 1;
              end else begin
                chk($sformatf("rnd%0d_ir_data", n), d, 16'h0);
                m_ir_r[ch] = 1;
              end
            end
          end else if (hit) begin
            if ((off % 4) >= 2) begin
              if (word || (off % 2) == 0) m_addr[ch][7:0] = wd[7:0];
              if (word || (off % 2) == 1) m_addr[ch][15:8] = wd[15:8];
              m_sa_w[ch] = 1;
            end else begin
              m_ir_w[ch] = 1;
            end
          end
        end
      endcase
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk($sformatf("rnd%0d_irq", n), irq, m_irq());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
